td4_core: RTL and testbench

- Execution core of the TD4 4-bit CPU. It drives the instruction ROM address (PC) and consumes the 8-bit instruction word returned in the same cycle.
- Holds registers A, B, OUT, PC and the carry flag. Executes one instruction per execute tick.
- The tick comes from a built-in clock prescaler in run mode, or from a debounced-edge single step.
- Sits directly downstream of the instruction ROM; out_port drives the board LEDs.

---
 rtl/td4_pkg.sv | 29 ++
 rtl/td4_alu.sv | 19 +
 rtl/td4_core.sv | 160 ++++++++++++++++
 tb/tb_td4_core.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/td4_pkg.sv
// ---------------------------------------------------------------------------
// td4_pkg
// Shared definitions for the TD4 4-bit CPU core.
//   - DATA_W / INSTR_W : register and instruction word widths
//   - data_t / instr_t : convenience types for those widths
//   - OP_*             : 4-bit opcodes found in instruction bits [7:4]
// ---------------------------------------------------------------------------
package td4_pkg;

  localparam int DATA_W  = 4;
  localparam int INSTR_W = 8;

  typedef logic [DATA_W-1:0]  data_t;
  typedef logic [INSTR_W-1:0] instr_t;

  localparam logic [3:0] OP_ADD_A  = 4'b0000;  // A <= A + imm
  localparam logic [3:0] OP_MOV_AB = 4'b0001;  // A <= B
  localparam logic [3:0] OP_IN_A   = 4'b0010;  // A <= synchronized input
  localparam logic [3:0] OP_MOV_AI = 4'b0011;  // A <= imm
  localparam logic [3:0] OP_MOV_BA = 4'b0100;  // B <= A
  localparam logic [3:0] OP_ADD_B  = 4'b0101;  // B <= B + imm
  localparam logic [3:0] OP_IN_B   = 4'b0110;  // B <= synchronized input
  localparam logic [3:0] OP_MOV_BI = 4'b0111;  // B <= imm
  localparam logic [3:0] OP_OUT_B  = 4'b1001;  // OUT <= B
  localparam logic [3:0] OP_OUT_I  = 4'b1011;  // OUT <= imm
  localparam logic [3:0] OP_JNC    = 4'b1110;  // PC <= imm when carry is clear
  localparam logic [3:0] OP_JMP    = 4'b1111;  // PC <= imm

endpackage

// File: rtl/td4_alu.sv
// ---------------------------------------------------------------------------
// td4_alu
// Purely combinational 4-bit adder used by the ADD instructions.
//   a, b : operands (register value and immediate)
//   sum  : low 4 bits of a + b (wraps mod 16)
//   cout : carry out of bit 3
// ---------------------------------------------------------------------------
module td4_alu
  import td4_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] sum,
  output logic              cout
);

  assign {cout, sum} = {1'b0, a} + {1'b0, b};

endmodule

// File: rtl/td4_core.sv
// ---------------------------------------------------------------------------
// td4_core
// Execution core of the TD4 4-bit CPU: registers A, B, OUT, PC and carry,
// one instruction executed per tick. Ticks come from a prescaler in run mode
// or from the rising edge of step in single-step mode.
//
// Ports:
//   clk      : system clock
//   rst      : asynchronous active-low reset
//   run      : 1 = free-run via prescaler, 0 = single-step
//   step     : single-step request, rising edge gives one tick when run=0
//   in_port  : switch input, asynchronous to clk (2-flop synchronized)
//   rom_data : instruction word, [7:4] opcode, [3:0] immediate
//   rom_addr : instruction address (PC), combinational from the register
//   out_port : OUT register
//   exec     : one-clock pulse in the cycle after an instruction commits
//
// Optional build macro TD4_DEBUG_EN adds register taps dbg_a, dbg_b and
// dbg_carry. Core behaviour does not depend on it.
// ---------------------------------------------------------------------------
module td4_core
  import td4_pkg::*;
#(
  parameter int STEP_DIV = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               run,
  input  logic               step,
  input  logic [DATA_W-1:0]  in_port,
  input  logic [INSTR_W-1:0] rom_data,
  output logic [DATA_W-1:0]  rom_addr,
  output logic [DATA_W-1:0]  out_port,
  output logic               exec
`ifdef TD4_DEBUG_EN
  ,
  output logic [DATA_W-1:0]  dbg_a,
  output logic [DATA_W-1:0]  dbg_b,
  output logic               dbg_carry
`endif
);

  // Prescaler counter is at least one bit wide even when STEP_DIV is 1.
  localparam int CNT_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STEP_DIV - 1);

  data_t            a_reg, b_reg, out_reg, pc_reg;
  logic             carry_reg;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             step_d_reg;
  data_t            sync1_reg, sync2_reg;
  logic             exec_reg;

  data_t            a_next, b_next, out_next, pc_next;
  logic             carry_next;
  logic             tick;

  logic [3:0]       opcode;
  data_t            imm;
  data_t            alu_a, alu_sum;
  logic             alu_cout;

  assign opcode = rom_data[7:4];
  assign imm    = rom_data[3:0];

  // Tick source. In step mode the counter is parked at 0 so that a later
  // switch to run mode sees a full STEP_DIV period before its first tick.
  always_comb begin
    cnt_next = '0;
    tick     = 1'b0;
    if (run) begin
      tick     = (cnt_reg == CNT_LAST);
      cnt_next = tick ? '0 : cnt_reg + CNT_W'(1);
    end else begin
      tick     = step & ~step_d_reg;
    end
  end

  // Only ADD B uses B as the adder operand; every other case feeds A, and
  // the adder result is only consumed by the two ADD opcodes.
  assign alu_a = (opcode == OP_ADD_B) ? b_reg : a_reg;

  td4_alu u_alu (
    .a    (alu_a),
    .b    (imm),
    .sum  (alu_sum),
    .cout (alu_cout)
  );

  // Next architectural state, applied only on tick. Carry defaults to 0 so
  // that every non-ADD instruction (NOP included) clears it.
  always_comb begin
    a_next     = a_reg;
    b_next     = b_reg;
    out_next   = out_reg;
    pc_next    = pc_reg + DATA_W'(1);
    carry_next = 1'b0;
    unique case (opcode)
      OP_ADD_A: begin
        a_next     = alu_sum;
        carry_next = alu_cout;
      end
      OP_MOV_AB: a_next = b_reg;
      OP_IN_A:   a_next = sync2_reg;
      OP_MOV_AI: a_next = imm;
      OP_MOV_BA: b_next = a_reg;
      OP_ADD_B: begin
        b_next     = alu_sum;
        carry_next = alu_cout;
      end
      OP_IN_B:   b_next   = sync2_reg;
      OP_MOV_BI: b_next   = imm;
      OP_OUT_B:  out_next = b_reg;
      OP_OUT_I:  out_next = imm;
      // JNC tests the carry left by the previous instruction.
      OP_JNC:    if (!carry_reg) pc_next = imm;
      OP_JMP:    pc_next = imm;
      default:   ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_reg      <= '0;
      b_reg      <= '0;
      out_reg    <= '0;
      pc_reg     <= '0;
      carry_reg  <= 1'b0;
      cnt_reg    <= '0;
      step_d_reg <= 1'b0;
      sync1_reg  <= '0;
      sync2_reg  <= '0;
      exec_reg   <= 1'b0;
    end else begin
      cnt_reg    <= cnt_next;
      step_d_reg <= step;
      sync1_reg  <= in_port;
      sync2_reg  <= sync1_reg;
      exec_reg   <= tick;
      if (tick) begin
        a_reg     <= a_next;
        b_reg     <= b_next;
        out_reg   <= out_next;
        pc_reg    <= pc_next;
        carry_reg <= carry_next;
      end
    end
  end

  assign rom_addr = pc_reg;
  assign out_port = out_reg;
  assign exec     = exec_reg;

`ifdef TD4_DEBUG_EN
  assign dbg_a     = a_reg;
  assign dbg_b     = b_reg;
  assign dbg_carry = carry_reg;
`endif

endmodule

// File: tb/tb_td4_core.sv
// ---------------------------------------------------------------------------
// tb_td4_core
// Bench for td4_core. dut1 uses STEP_DIV=1, dut4 uses STEP_DIV=4; both read
// the same bench-owned ROM array. A behavioural model of the instruction set
// tracks dut1's architectural state.
// ---------------------------------------------------------------------------
module tb_td4_core;

  logic       clk = 1'b0;
  logic       rst;
  logic       run1, run4, step1, step4;
  logic [3:0] in_port;
  logic [7:0] rom [16];

  logic [3:0] rom_addr1, out_port1, rom_addr4, out_port4;
  logic [7:0] rom_data1, rom_data4;
  logic       exec1, exec4;

  assign rom_data1 = rom[rom_addr1];
  assign rom_data4 = rom[rom_addr4];

  always #5 clk = ~clk;

  td4_core #(.STEP_DIV(1)) dut1 (
    .clk(clk), .rst(rst), .run(run1), .step(step1), .in_port(in_port),
    .rom_data(rom_data1), .rom_addr(rom_addr1), .out_port(out_port1),
    .exec(exec1)
  );

  td4_core #(.STEP_DIV(4)) dut4 (
    .clk(clk), .rst(rst), .run(run4), .step(step4), .in_port(in_port),
    .rom_data(rom_data4), .rom_addr(rom_addr4), .out_port(out_port4),
    .exec(exec4)
  );

  int total  = 0;
  int passed = 0;
  int failed = 0;

  // Reference model state for dut1.
  int m_a, m_b, m_out, m_pc, m_c, m_s1, m_s2, m_exec;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    m_a = 0; m_b = 0; m_out = 0; m_pc = 0; m_c = 0;
    m_s1 = 0; m_s2 = 0; m_exec = 0;
  endtask

  // One instruction, straight from the opcode table.
  task automatic m_step(input logic [7:0] ins);
    int op, im, c_old, sum;
    op    = int'(ins[7:4]);
    im    = int'(ins[3:0]);
    c_old = m_c;
    m_c   = 0;
    m_pc  = (m_pc + 1) % 16;
    case (op)
      0:  begin sum = m_a + im; m_a = sum % 16; m_c = (sum >= 16) ? 1 : 0; end
      1:  m_a = m_b;
      2:  m_a = m_s2;
      3:  m_a = im;
      4:  m_b = m_a;
      5:  begin sum = m_b + im; m_b = sum % 16; m_c = (sum >= 16) ? 1 : 0; end
      6:  m_b = m_s2;
      7:  m_b = im;
      9:  m_out = m_b;
      11: m_out = im;
      14: if (c_old == 0) m_pc = im;
      15: m_pc = im;
      default: ;
    endcase
  endtask

  // Advance one clock; t1 says whether dut1 should commit on this edge.
  // The input seen by IN is the value sampled two edges earlier.
  task automatic clk_edge(input bit t1);
    @(posedge clk);
    if (t1) m_step(rom[m_pc]);
    m_s2   = m_s1;
    m_s1   = int'(in_port);
    m_exec = t1 ? 1 : 0;
    #1;
  endtask

  task automatic chk_model(input string tag);
    chk({tag, "_pc"},   {4'h0, rom_addr1}, 8'(m_pc));
    chk({tag, "_out"},  {4'h0, out_port1}, 8'(m_out));
    chk({tag, "_exec"}, {7'h0, exec1},     8'(m_exec));
  endtask

  task automatic do_reset();
    rst = 1'b0;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic fill_rom(input logic [7:0] v);
    for (int i = 0; i < 16; i++) rom[i] = v;
  endtask

  task automatic step_pulse(input string tag);
    step1 = 1'b1;
    clk_edge(1);
    chk({tag, "_exec"}, {7'h0, exec1}, 8'h01);
    step1 = 1'b0;
    clk_edge(0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] led_exp [10];
    logic [7:0] led_prog [10];
    led_prog = '{8'hB3, 8'hB6, 8'hBC, 8'hB8, 8'hB8, 8'hBC, 8'hB6, 8'hB3, 8'hB1, 8'hF0};
    led_exp  = '{4'h3, 4'h6, 4'hC, 4'h8, 4'h8, 4'hC, 4'h6, 4'h3, 4'h1, 4'h1};

    rst = 1'b0; run1 = 1'b0; run4 = 1'b0; step1 = 1'b0; step4 = 1'b0;
    in_port = 4'h0;
    model_clear();
    fill_rom(8'hC0);
    for (int i = 0; i < 10; i++) rom[i] = led_prog[i];

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    chk("rst_addr1", {4'h0, rom_addr1}, 8'h00);
    chk("rst_out1",  {4'h0, out_port1}, 8'h00);
    chk("rst_exec1", {7'h0, exec1},     8'h00);
    chk("rst_addr4", {4'h0, rom_addr4}, 8'h00);
    rst = 1'b1;
    repeat (3) clk_edge(0);
    chk_model("idle");

    // LED program, free run at one instruction per clock.
    run1 = 1'b1;
    for (int i = 0; i < 10; i++) begin
      clk_edge(1);
      chk($sformatf("led_out%0d", i), {4'h0, out_port1}, {4'h0, led_exp[i]});
      chk_model($sformatf("led%0d", i));
    end
    chk("led_pc_wrap", {4'h0, rom_addr1}, 8'h00);
    for (int i = 0; i < 7; i++) clk_edge(1);
    chk("pre_rst_pc",  {4'h0, rom_addr1}, 8'h07);
    chk("pre_rst_out", {4'h0, out_port1}, 8'h06);

    // Asynchronous reset mid-run, observed before the next clock edge.
    #2;
    rst = 1'b0;
    #1;
    chk("async_rst_pc",   {4'h0, rom_addr1}, 8'h00);
    chk("async_rst_out",  {4'h0, out_port1}, 8'h00);
    chk("async_rst_exec", {7'h0, exec1},     8'h00);
    do_reset();
    chk("fetch0", {4'h0, rom_addr1}, 8'h00);
    clk_edge(1);
    chk("first_tick_out", {4'h0, out_port1}, 8'h03);
    chk_model("first_tick");
    run1 = 1'b0;

    // Carry out of ADD, JNC not taken.
    fill_rom(8'hC0);
    rom[0] = 8'h3F; rom[1] = 8'h01; rom[2] = 8'hE0;
    do_reset();
    run1 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      clk_edge(1);
      chk_model($sformatf("jnc_nt%0d", i));
    end
    run1 = 1'b0;
    chk("jnc_not_taken", {4'h0, rom_addr1}, 8'h03);

    // No carry, JNC taken.
    rom[0] = 8'h3E;
    do_reset();
    run1 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      clk_edge(1);
      chk_model($sformatf("jnc_t%0d", i));
    end
    run1 = 1'b0;
    chk("jnc_taken", {4'h0, rom_addr1}, 8'h00);

    // IN path and synchronizer latency.
    fill_rom(8'hC0);
    rom[0] = 8'h20; rom[1] = 8'h40; rom[2] = 8'h90;
    rom[3] = 8'h20; rom[4] = 8'h40; rom[5] = 8'h90;
    rom[6] = 8'h20; rom[7] = 8'h40; rom[8] = 8'h90;
    in_port = 4'hA;
    do_reset();
    repeat (3) clk_edge(0);
    run1 = 1'b1;
    for (int i = 0; i < 3; i++) clk_edge(1);
    run1 = 1'b0;
    chk("in_path", {4'h0, out_port1}, 8'h0A);
    in_port = 4'h5;
    step_pulse("in_s0");
    step_pulse("in_s1");
    step_pulse("in_s2");
    chk("in_delay_old", {4'h0, out_port1}, 8'h0A);
    chk_model("in_old");
    step_pulse("in_s3");
    step_pulse("in_s4");
    step_pulse("in_s5");
    chk("in_delay_new", {4'h0, out_port1}, 8'h05);
    chk_model("in_new");

    // Single step: a held step yields exactly one tick.
    fill_rom(8'hC0);
    do_reset();
    clk_edge(0);
    step1 = 1'b1;
    for (int k = 0; k < 5; k++) begin
      clk_edge(k == 0);
      chk($sformatf("hold_exec%0d", k), {7'h0, exec1}, (k == 0) ? 8'h01 : 8'h00);
    end
    chk("hold_pc", {4'h0, rom_addr1}, 8'h01);
    step1 = 1'b0;
    clk_edge(0);
    step1 = 1'b1;
    clk_edge(1);
    chk("second_step_pc", {4'h0, rom_addr1}, 8'h02);
    step1 = 1'b0;
    clk_edge(0);
    chk_model("step_done");

    // Prescaler with STEP_DIV=4; step edges toggle and must be ignored.
    do_reset();
    run4 = 1'b1;
    for (int k = 1; k <= 18; k++) begin
      step4 = k[0];
      @(posedge clk);
      #1;
      chk($sformatf("div4_exec%0d", k), {7'h0, exec4}, (k % 4 == 0) ? 8'h01 : 8'h00);
      chk($sformatf("div4_pc%0d", k), {4'h0, rom_addr4}, 8'(k / 4));
    end
    run4 = 1'b0;
    step4 = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      chk("div4_stop_exec", {7'h0, exec4}, 8'h00);
    end
    chk("div4_stop_pc", {4'h0, rom_addr4}, 8'h04);
    run4 = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk);
      #1;
      chk($sformatf("div4_restart_exec%0d", k), {7'h0, exec4}, (k == 4) ? 8'h01 : 8'h00);
    end
    chk("div4_restart_pc", {4'h0, rom_addr4}, 8'h05);
    run4 = 1'b0;

    // Randomized programs with a changing input port.
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < 16; i++) rom[i] = 8'($urandom_range(0, 255));
      in_port = 4'($urandom_range(0, 15));
      do_reset();
      for (int i = 0; i < 3; i++) clk_edge(0);
      run1 = 1'b1;
      for (int i = 0; i < 40; i++) begin
        if ($urandom_range(0, 3) == 0) in_port = 4'($urandom_range(0, 15));
        clk_edge(1);
        chk_model($sformatf("rnd%0d_%0d", r, i));
      end
      run1 = 1'b0;
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
